// File: rtl/mult_pkg.sv
// Shared definitions for the shift-add multiplier: FSM encoding and default width.
package mult_pkg;

  localparam int unsigned DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mult_state_t;

endpackage

// File: rtl/mult_control.sv
// Sequencer for the shift-add multiplier: FSM plus iteration counter.
module mult_control
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic clk,
  input  logic Reset,
  input  logic Run,
  input  logic Product_lsb,
  output logic Load_ctrl,
  output logic Add_ctrl,
  output logic SRL_ctrl,
  output logic Ready
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  mult_state_t      state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  // State and counter registers
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state, counter update and datapath strobes
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    Load_ctrl = 1'b0;
    Add_ctrl  = 1'b0;
    SRL_ctrl  = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        if (Run) begin
          Load_ctrl = 1'b1;
          cnt_nxt   = '0;
          state_nxt = CALC;
        end
      end
      CALC: begin
        SRL_ctrl = 1'b1;
        Add_ctrl = Product_lsb;
        cnt_nxt  = CNT_W'(cnt + CNT_W'(1));
        if (cnt == CNT_W'(WIDTH - 1)) begin
          state_nxt = DONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Ready decodes the registered state, so it is glitch-free and only high in DONE
  assign Ready = (state == DONE);

endmodule

// File: rtl/comp_multiplier.sv
// Unsigned shift-add multiplier retiring one multiplier bit per clock.
module comp_multiplier
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               Reset,
  input  logic               Run,
  input  logic [WIDTH-1:0]   Multiplicand_in,
  input  logic [WIDTH-1:0]   Multiplier_in,
  output logic [2*WIDTH-1:0] Product_out,
  output logic               Ready
);

  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] product;
  logic [WIDTH:0]     sum;
  logic               load_ctrl, add_ctrl, srl_ctrl;

  mult_control #(.WIDTH(WIDTH)) u_ctrl (
    .clk         (clk),
    .Reset       (Reset),
    .Run         (Run),
    .Product_lsb (product[0]),
    .Load_ctrl   (load_ctrl),
    .Add_ctrl    (add_ctrl),
    .SRL_ctrl    (srl_ctrl),
    .Ready       (Ready)
  );

  // Upper half plus (optionally) the multiplicand, keeping the carry-out
  always_comb begin
    sum = {1'b0, product[2*WIDTH-1:WIDTH]};
    if (add_ctrl) begin
      sum = sum + {1'b0, mcand};
    end
  end

  // Operand latch and product shift register; carry enters at the MSB
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      mcand   <= '0;
      product <= '0;
    end else if (load_ctrl) begin
      mcand   <= Multiplicand_in;
      product <= {{WIDTH{1'b0}}, Multiplier_in};
    end else if (srl_ctrl) begin
      product <= {sum, product[WIDTH-1:1]};
    end
  end

  assign Product_out = product;

endmodule

// File: tb/tb_comp_multiplier.sv
// Directed bench for comp_multiplier with a queue of expected products.
module tb_comp_multiplier;

  localparam int unsigned W = 32;

  logic           clk = 1'b0;
  logic           Reset;
  logic           Run;
  logic [W-1:0]   Multiplicand_in;
  logic [W-1:0]   Multiplier_in;
  logic [2*W-1:0] Product_out;
  logic           Ready;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int load_cyc = 0;
  logic [2*W-1:0] exp_q[$];
  logic [2*W-1:0] exp_v;
  logic [2*W-1:0] held;

  comp_multiplier #(.WIDTH(W)) dut (
    .clk             (clk),
    .Reset           (Reset),
    .Run             (Run),
    .Multiplicand_in (Multiplicand_in),
    .Multiplier_in   (Multiplier_in),
    .Product_out     (Product_out),
    .Ready           (Ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [2*W-1:0] obs, input logic [2*W-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive a load request, record the expected product and the load edge
  task automatic start(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    Run = 1'b1;
    Multiplicand_in = a;
    Multiplier_in = b;
    exp_q.push_back((2*W)'(a) * (2*W)'(b));
    @(posedge clk);
    load_cyc = cyc + 1;
    #1;
    check("ready_low_after_load", {63'b0, Ready}, 64'd0);
    @(negedge clk);
    Run = 1'b0;
  endtask

  // Wait for Ready (bounded), check latency and pop/compare the product
  task automatic finish_op(input string tag);
    int guard;
    guard = 0;
    while (Ready !== 1'b1 && guard < 80) begin
      @(posedge clk);
      #1;
      guard++;
    end
    check({tag, "_latency"}, 64'(cyc - load_cyc), 64'd32);
    if (exp_q.size() > 0) exp_v = exp_q.pop_front();
    else exp_v = 'x;
    check({tag, "_product"}, Product_out, exp_v);
  endtask

  initial begin
    Reset = 1'b1;
    Run = 1'b0;
    Multiplicand_in = '0;
    Multiplier_in = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_product", Product_out, 64'd0);
    check("reset_ready", {63'b0, Ready}, 64'd0);
    @(negedge clk);
    Reset = 1'b0;

    // Idle with Run low keeps outputs unchanged
    repeat (5) @(posedge clk);
    #1;
    check("idle_product", Product_out, 64'd0);
    check("idle_ready", {63'b0, Ready}, 64'd0);

    start(32'd3, 32'd5);
    finish_op("3x5");
    check("3x5_const", Product_out, 64'h0000_0000_0000_000F);

    // DONE holds until Run
    held = Product_out;
    repeat (6) @(posedge clk);
    #1;
    check("done_hold_product", Product_out, held);
    check("done_hold_ready", {63'b0, Ready}, 64'd1);

    // Back-to-back reload from DONE; start() checks Ready fell on the load edge
    start(32'd6, 32'd7);
    finish_op("6x7");
    check("6x7_const", Product_out, 64'd42);

    start(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    finish_op("ffxff");
    check("ffxff_const", Product_out, 64'hFFFF_FFFE_0000_0001);

    start(32'd0, 32'h1234_5678);
    finish_op("0xk");

    start(32'h1234_5678, 32'd1);
    finish_op("kx1");
    check("kx1_const", Product_out, 64'h0000_0000_1234_5678);

    // Run toggling and operand changes during CALC are ignored
    start(32'd7, 32'd9);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      Run = ~Run;
      Multiplicand_in = 32'hAAAA_AAAA;
      Multiplier_in = 32'hAAAA_AAAA;
    end
    @(negedge clk);
    Run = 1'b0;
    finish_op("7x9_noisy");
    check("7x9_const", Product_out, 64'd63);

    // Reset 10 edges into CALC aborts immediately
    @(negedge clk);
    Run = 1'b1;
    Multiplicand_in = 32'hDEAD_BEEF;
    Multiplier_in = 32'h0BAD_F00D;
    @(posedge clk);
    #1;
    @(negedge clk);
    Run = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    Reset = 1'b1;
    #1;
    check("abort_product", Product_out, 64'd0);
    check("abort_ready", {63'b0, Ready}, 64'd0);
    @(negedge clk);
    Reset = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check("abort_no_ready", {63'b0, Ready}, 64'd0);
    check("abort_idle_product", Product_out, 64'd0);

    start(32'd2, 32'd2);
    finish_op("2x2");

    // Run on the same edge as Reset is ignored
    @(negedge clk);
    Reset = 1'b1;
    Run = 1'b1;
    Multiplicand_in = 32'd11;
    Multiplier_in = 32'd13;
    @(posedge clk);
    #1;
    check("run_in_reset_product", Product_out, 64'd0);
    @(negedge clk);
    Reset = 1'b0;
    Run = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check("run_in_reset_ready", {63'b0, Ready}, 64'd0);
    check("run_in_reset_idle", Product_out, 64'd0);

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
